// File: rtl/prefetch_request_queue.sv
// Prefetch request queue: line-aligns, deduplicates and buffers prefetch addresses, issues them under an
// outstanding limit and pulses a fill notification per completed line. Optional counters: PREFETCH_QUEUE_STATS_EN.
module prefetch_request_queue #(
    parameter int WIDTH           = 64,
    parameter int LINE_SIZE       = 256,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pf_address_i,
    input  logic                     pf_valid_i,
    output logic                     pf_ready_o,
    input  logic [WIDTH-1:0]         demand_address_i,
    input  logic                     demand_valid_i,
    output logic [WIDTH-1:0]         mem_req_address_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    input  logic [WIDTH-1:0]         mem_resp_address_i,
    input  logic                     mem_resp_valid_i,
    output logic [WIDTH-1:0]         fill_address_o,
    output logic                     fill_valid_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef PREFETCH_QUEUE_STATS_EN
    ,
    output logic [15:0]              stat_issued_o,
    output logic [15:0]              stat_dropped_o,
    output logic [15:0]              stat_squashed_o
`endif
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int OST_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int OSTI_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [WIDTH-1:0] LINE_MASK = ~(WIDTH'(LINE_SIZE - 1));

    typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;
    state_t state_reg, state_next;

    logic [WIDTH-1:0]           fifo_addr [DEPTH];
    logic [DEPTH-1:0]           fifo_valid_reg, fifo_valid_next;
    logic [PTR_W-1:0]           head_reg, tail_reg;
    logic [WIDTH-1:0]           ost_addr [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] ost_valid_reg, ost_valid_next, ost_free;
    logic [WIDTH-1:0]           fill_addr_reg;
    logic                       fill_valid_reg;

    logic [WIDTH-1:0] pf_line, demand_line, resp_line;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0] fifo_hit, squash_hit;
    logic [MAX_OUTSTANDING-1:0] ost_hit_pf, ost_hit_resp;
    logic [OST_W-1:0]  ost_count;
    logic [OSTI_W-1:0] alloc_idx;
    logic alloc_found, presenting, empty, full, head_live;
    logic start_issue, issue_fire, bubble_pop, pop, accept, drop, push, resp_hit;

    assign pf_line     = pf_address_i & LINE_MASK;
    assign demand_line = demand_address_i & LINE_MASK;
    assign resp_line   = mem_resp_address_i & LINE_MASK;
    assign head_idx    = head_reg[IDX_W-1:0];
    assign tail_idx    = tail_reg[IDX_W-1:0];
    assign occupancy_o = tail_reg - head_reg;
    assign empty       = (occupancy_o == '0);
    assign full        = (occupancy_o == PTR_W'(DEPTH));
    assign pf_ready_o  = rst && !full;
    assign presenting  = (state_reg == S_PRESENT);

    // The entry on mem_req_* is immune to squashing so the presented address never changes.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo_cmp
        assign fifo_hit[gi]   = fifo_valid_reg[gi] && (fifo_addr[gi] == pf_line);
        assign squash_hit[gi] = demand_valid_i && fifo_valid_reg[gi] && (fifo_addr[gi] == demand_line)
                                && !(presenting && (head_idx == IDX_W'(gi)));
    end

    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_ost_cmp
        assign ost_hit_pf[gi]   = ost_valid_reg[gi] && (ost_addr[gi] == pf_line);
        assign ost_hit_resp[gi] = ost_valid_reg[gi] && mem_resp_valid_i && (ost_addr[gi] == resp_line);
    end

    // A head squashed in this very cycle is treated as a bubble, never presented.
    assign head_live   = fifo_valid_reg[head_idx] && !squash_hit[head_idx];
    assign bubble_pop  = !presenting && !empty && !head_live;
    assign start_issue = !presenting && !empty && head_live && (ost_count < OST_W'(MAX_OUTSTANDING));
    assign issue_fire  = presenting && mem_req_ready_i;
    assign pop         = bubble_pop || issue_fire;
    assign accept      = pf_valid_i && pf_ready_o;
    assign drop        = accept && ((|fifo_hit) || (|ost_hit_pf) || (demand_valid_i && (demand_line == pf_line)));
    assign push        = accept && !drop;
    assign resp_hit    = |ost_hit_resp;

    always_comb begin
        ost_count = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) ost_count = ost_count + OST_W'(ost_valid_reg[i]);
    end

    // Slot freed by a response this cycle is already available to the issue handshake.
    always_comb begin
        ost_free    = ost_valid_reg & ~ost_hit_resp;
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!alloc_found && !ost_free[i]) begin
                alloc_idx   = OSTI_W'(i);
                alloc_found = 1'b1;
            end
        end
        ost_valid_next = ost_free;
        if (issue_fire) ost_valid_next[alloc_idx] = 1'b1;
    end

    always_comb begin
        fifo_valid_next = fifo_valid_reg & ~squash_hit;
        if (pop)  fifo_valid_next[head_idx] = 1'b0;
        if (push) fifo_valid_next[tail_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start_issue)     state_next = S_PRESENT;
            S_PRESENT: if (mem_req_ready_i) state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid_o   = presenting;
        mem_req_address_o = presenting ? fifo_addr[head_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            fifo_valid_reg <= '0;
            ost_valid_reg  <= '0;
            fill_valid_reg <= 1'b0;
            fill_addr_reg  <= '0;
        end else begin
            if (pop)  head_reg <= head_reg + 1'b1;
            if (push) tail_reg <= tail_reg + 1'b1;
            fifo_valid_reg <= fifo_valid_next;
            ost_valid_reg  <= ost_valid_next;
            fill_valid_reg <= resp_hit;
            if (resp_hit) fill_addr_reg <= resp_line;
        end
    end

    always_ff @(posedge clk) begin
        if (push)       fifo_addr[tail_idx] <= pf_line;
        if (issue_fire) ost_addr[alloc_idx] <= fifo_addr[head_idx];
    end

    assign fill_valid_o   = fill_valid_reg;
    assign fill_address_o = fill_addr_reg;

`ifdef PREFETCH_QUEUE_STATS_EN
    logic [15:0] issued_reg, dropped_reg, squashed_reg;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_reg   <= '0;
            dropped_reg  <= '0;
            squashed_reg <= '0;
        end else begin
            issued_reg   <= sat_add(issued_reg, 16'(issue_fire));
            dropped_reg  <= sat_add(dropped_reg, 16'(drop));
            squashed_reg <= sat_add(squashed_reg, 16'($countones(squash_hit)));
        end
    end

    assign stat_issued_o   = issued_reg;
    assign stat_dropped_o  = dropped_reg;
    assign stat_squashed_o = squashed_reg;
`endif
endmodule

// File: tb/tb_prefetch_request_queue.sv
// Bench for prefetch_request_queue: directed scenarios plus random traffic, all cross-checked every cycle
// against a queue-based transaction model (stats checked when PREFETCH_QUEUE_STATS_EN is defined).
module tb_prefetch_request_queue;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pf_address, demand_address, mem_resp_address;
    logic        pf_valid, demand_valid, mem_req_ready, mem_resp_valid;
    logic [63:0] mem_req_address_o, fill_address_o;
    logic        pf_ready_o, mem_req_valid_o, fill_valid_o;
    logic [3:0]  occupancy_o;
`ifdef PREFETCH_QUEUE_STATS_EN
    logic [15:0] stat_issued_o, stat_dropped_o, stat_squashed_o;
`endif

    always #5 clk = ~clk;

    prefetch_request_queue dut (
        .clk(clk), .rst(rst),
        .pf_address_i(pf_address), .pf_valid_i(pf_valid), .pf_ready_o(pf_ready_o),
        .demand_address_i(demand_address), .demand_valid_i(demand_valid),
        .mem_req_address_o(mem_req_address_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready),
        .mem_resp_address_i(mem_resp_address), .mem_resp_valid_i(mem_resp_valid),
        .fill_address_o(fill_address_o), .fill_valid_o(fill_valid_o),
        .occupancy_o(occupancy_o)
`ifdef PREFETCH_QUEUE_STATS_EN
        , .stat_issued_o(stat_issued_o), .stat_dropped_o(stat_dropped_o), .stat_squashed_o(stat_squashed_o)
`endif
    );

    typedef struct {logic [63:0] a; bit v;} ent_t;
    ent_t        mq[$];
    logic [63:0] mo[$];
    logic [63:0] issue_log[$];
    int          n_cmp = 0, n_err = 0;
    bit          exp_fill_v = 0;
    logic [63:0] exp_fill_a = '0;
    int          m_issued = 0, m_dropped = 0, m_squashed = 0;
    bit          prev_present = 0, prev_ready = 0;
    logic [63:0] prev_addr = '0;

    function automatic logic [63:0] lnof(input logic [63:0] a);
        return a & ~64'hFF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, check against model, advance model, then move past the edge.
    task automatic tick();
        int fidx;
        bit s_acc, drop, fire, found;
        logic [63:0] pl, dl, rl, iss;
        @(negedge clk);
        if (!rst) begin
            mq.delete(); mo.delete(); exp_fill_v = 0; prev_present = 0;
            m_issued = 0; m_dropped = 0; m_squashed = 0;
        end else begin
            chk("fill_valid", fill_valid_o, exp_fill_v);
            if (exp_fill_v) chk("fill_address", fill_address_o, exp_fill_a);
            if (prev_present && !prev_ready) begin
                chk("req_hold_valid", mem_req_valid_o, 1);
                chk("req_hold_addr", mem_req_address_o, prev_addr);
            end
            fidx = -1;
            foreach (mq[i]) if (fidx < 0 && mq[i].v) fidx = i;
            s_acc = pf_valid && pf_ready_o;
            pl = lnof(pf_address);
            dl = lnof(demand_address);
            drop = 0;
            if (s_acc) begin
                foreach (mq[i]) if (mq[i].v && mq[i].a == pl) drop = 1;
                foreach (mo[i]) if (mo[i] == pl) drop = 1;
                if (demand_valid && dl == pl) drop = 1;
            end
            if (demand_valid)
                foreach (mq[i])
                    if (mq[i].v && mq[i].a == dl && !(mem_req_valid_o && i == fidx)) begin
                        mq[i].v = 0;
                        m_squashed++;
                    end
            fire = mem_req_valid_o && mem_req_ready;
            iss = mem_req_address_o;
            if (fire) begin
                chk("issue_has_entry", (fidx >= 0), 1);
                chk("issue_limit", (mo.size() < MAXO), 1);
                if (fidx >= 0) begin
                    chk("issue_address", iss, mq[fidx].a);
                    for (int j = 0; j <= fidx; j++) void'(mq.pop_front());
                end
                issue_log.push_back(iss);
                m_issued++;
            end
            exp_fill_v = 0;
            if (mem_resp_valid) begin
                rl = lnof(mem_resp_address);
                found = 0;
                foreach (mo[i]) if (!found && mo[i] == rl) begin
                    mo.delete(i);
                    found = 1;
                end
                exp_fill_v = found;
                exp_fill_a = rl;
            end
            if (fire) mo.push_back(iss);
            if (s_acc && !drop) mq.push_back('{a: pl, v: 1'b1});
            if (s_acc && drop) m_dropped++;
            prev_present = mem_req_valid_o;
            prev_ready   = mem_req_ready;
            prev_addr    = mem_req_address_o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [63:0] a);
        pf_address = a;
        pf_valid   = 1;
        tick();
        pf_valid   = 0;
    endtask

    task automatic drain(input string tag);
        bit done;
        int vc;
        done = 0;
        mem_req_ready = 1; pf_valid = 0; demand_valid = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (mo.size() > 0) begin
                mem_resp_address = mo[0];
                mem_resp_valid   = 1;
            end else mem_resp_valid = 0;
            tick();
            vc = 0;
            foreach (mq[i]) if (mq[i].v) vc++;
            done = (vc == 0 && mo.size() == 0 && occupancy_o == 0 && !mem_req_valid_o);
        end
        mem_resp_valid = 0;
        tick();
        mq.delete();
        chk({tag, "_drained"}, done, 1);
    endtask

    initial begin
        bit acc_seen;
        rst = 0; pf_valid = 0; demand_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        pf_address = '0; demand_address = '0; mem_resp_address = '0;
        repeat (3) tick();
        rst = 1;
        #1;
        chk("reset_occupancy", occupancy_o, 0);
        chk("reset_pf_ready", pf_ready_o, 1);
        chk("reset_req_valid", mem_req_valid_o, 0);
        chk("reset_req_addr", mem_req_address_o, 0);
        chk("reset_fill_valid", fill_valid_o, 0);
        chk("reset_fill_addr", fill_address_o, 0);

        // Single request round trip.
        mem_req_ready = 1;
        enq(64'h1234);
        tick();
        chk("t1_req_valid", mem_req_valid_o, 1);
        chk("t1_req_addr", mem_req_address_o, 64'h1200);
        tick();
        chk("t1_req_done", mem_req_valid_o, 0);
        mem_resp_address = 64'h1234; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        chk("t1_fill_valid", fill_valid_o, 1);
        chk("t1_fill_addr", fill_address_o, 64'h1200);
        tick();
        chk("t1_fill_pulse", fill_valid_o, 0);

        // Fill to capacity with memory stalled.
        issue_log.delete();
        mem_req_ready = 0;
        for (int i = 1; i <= 8; i++) enq(64'(i) << 8);
        chk("t2_occupancy_full", occupancy_o, 8);
        chk("t2_pf_ready_full", pf_ready_o, 0);
        pf_address = 64'h900; pf_valid = 1;
        repeat (3) tick();
        chk("t2_occupancy_held", occupancy_o, 8);
        mem_req_ready = 1;
        acc_seen = 0;
        for (int c = 0; c < 20 && !acc_seen; c++) begin
            acc_seen = pf_ready_o;
            tick();
        end
        pf_valid = 0;
        chk("t2_ninth_accepted", acc_seen, 1);
        drain("t2");
        chk("t2_issue_count", issue_log.size(), 9);
        foreach (issue_log[i]) chk("t2_issue_order", issue_log[i], 64'(i + 1) << 8);

        // Deduplication of two addresses in one line.
        issue_log.delete();
        mem_req_ready = 0;
        enq(64'h500);
        enq(64'h5FF);
        drain("t3");
        chk("t3_issue_count", issue_log.size(), 1);
        if (issue_log.size() > 0) chk("t3_issue_addr", issue_log[0], 64'h500);
`ifdef PREFETCH_QUEUE_STATS_EN
        chk("t3_stat_dropped", stat_dropped_o, 1);
`endif

        // Demand squash of a queued entry.
        issue_log.delete();
        mem_req_ready = 0;
        enq(64'h100); enq(64'h200); enq(64'h300);
        demand_address = 64'h2A0; demand_valid = 1;
        tick();
        demand_valid = 0;
        chk("t4_occupancy_bubble", occupancy_o, 3);
        drain("t4");
        chk("t4_issue_count", issue_log.size(), 2);
        if (issue_log.size() == 2) begin
            chk("t4_issue0", issue_log[0], 64'h100);
            chk("t4_issue1", issue_log[1], 64'h300);
        end
`ifdef PREFETCH_QUEUE_STATS_EN
        chk("t4_stat_squashed", stat_squashed_o, 1);
`endif

        // Outstanding limit.
        issue_log.delete();
        mem_req_ready = 1;
        for (int i = 1; i <= 6; i++) enq(64'(i) << 12);
        repeat (20) tick();
        chk("t5_issue_limit", issue_log.size(), 4);
        mem_resp_address = 64'h1000; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        repeat (10) tick();
        chk("t5_issue_after_free", issue_log.size(), 5);
        mem_resp_address = 64'hDEAD00; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        chk("t5_unknown_no_fill", fill_valid_o, 0);
        drain("t5");

        // Reset while presenting.
        mem_req_ready = 0;
        enq(64'hA000);
        tick();
        chk("t6_presenting", mem_req_valid_o, 1);
        rst = 0;
        #1;
        chk("t6_async_req_valid", mem_req_valid_o, 0);
        chk("t6_async_occupancy", occupancy_o, 0);
        repeat (2) tick();
        rst = 1;
        #1;
        chk("t6_occupancy", occupancy_o, 0);
        chk("t6_pf_ready", pf_ready_o, 1);
        mem_resp_address = 64'hA000; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        chk("t6_late_resp_no_fill", fill_valid_o, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            pf_valid       = ($urandom_range(0, 1) == 1);
            pf_address     = (64'($urandom_range(1, 12)) << 8) | 64'($urandom_range(0, 255));
            demand_valid   = ($urandom_range(0, 4) == 0);
            demand_address = (64'($urandom_range(1, 12)) << 8) | 64'($urandom_range(0, 255));
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            mem_resp_valid = 0;
            if (mo.size() > 0 && $urandom_range(0, 2) == 0) begin
                mem_resp_address = mo[$urandom_range(0, mo.size() - 1)] | 64'($urandom_range(0, 255));
                mem_resp_valid   = 1;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_resp_address = (64'($urandom_range(1, 12)) << 8);
                mem_resp_valid   = 1;
            end
            tick();
        end
        drain("rand");
`ifdef PREFETCH_QUEUE_STATS_EN
        chk("rand_stat_issued", stat_issued_o, 64'(m_issued));
        chk("rand_stat_dropped", stat_dropped_o, 64'(m_dropped));
        chk("rand_stat_squashed", stat_squashed_o, 64'(m_squashed));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/prefetch_request_queue.md
Name: prefetch_request_queue

Overview:
- Lower-level-cache end of the prefetch request interface; the best-offset prefetcher drives the other side.
- Accepts prefetch addresses with a valid/ready handshake, line-aligns and deduplicates them, and buffers them in a FIFO.
- Issues queued lines to memory subject to an outstanding-request limit.
- Returns a one-cycle fill notification per completed prefetch, which feeds the prefetcher's recent-requests table.

Parameters:
- WIDTH, 64, address width
- LINE_SIZE, 256, line size in bytes (power of 2); low $clog2(LINE_SIZE) address bits are cleared
- DEPTH, 8, FIFO entries (power of 2, >=2)
- MAX_OUTSTANDING, 4, issued-but-unfilled prefetches allowed (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- pf_address_i  in  WIDTH  prefetch address from prefetcher
- pf_valid_i  in  1  prefetch request valid
- pf_ready_o  out  1  queue can accept a request
- demand_address_i  in  WIDTH  demand access address at this cache
- demand_valid_i  in  1  demand access valid; squashes a matching queued prefetch
- mem_req_address_o  out  WIDTH  line-aligned prefetch address to memory
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_resp_address_i  in  WIDTH  completed line address
- mem_resp_valid_i  in  1  response valid (one cycle per line)
- fill_address_o  out  WIDTH  filled prefetch line address
- fill_valid_o  out  1  one-cycle fill pulse
- occupancy_o  out  $clog2(DEPTH)+1  FIFO slots in use, including squashed bubbles

Behaviour:
- Reset (rst=0, async):
  - FIFO and outstanding table are emptied; issue FSM goes to IDLE.
  - All outputs are 0, except pf_ready_o=1 once reset is released.
  - A reset mid-transaction discards all queued and outstanding state; responses that arrive later are unmatched and are ignored.
- Line alignment: every address compare and every stored address uses addr & ~(LINE_SIZE-1).
- Enqueue:
  - pf_ready_o = (occupancy_o != DEPTH), combinational from registered state. There is no bypass when full.
  - On pf_valid_i & pf_ready_o, the line is dropped if it matches a valid FIFO entry, an outstanding entry, or demand_address_i with demand_valid_i in the same cycle. Otherwise it is written at the tail and the tail pointer advances, wrapping mod DEPTH.
  - A dropped request still counts as accepted for the handshake.
- Squash: on demand_valid_i, every valid FIFO entry whose line matches is marked invalid. The entry currently presented on mem_req_* is exempt. Invalid entries stay in the FIFO as bubbles until they reach the head.
- Issue FSM:
  - IDLE: if the head entry is invalid, pop it (1 cycle per bubble). Else if the FIFO is non-empty and outstanding < MAX_OUTSTANDING, go to PRESENT; mem_req_valid_o rises the next cycle with the head address.
  - PRESENT: mem_req_valid_o=1 and the address is held stable until mem_req_ready_i. On handshake, the head is popped, the address is written to a free outstanding slot, and the FSM returns to IDLE. Minimum issue spacing is 2 cycles.
- Response:
  - On mem_resp_valid_i whose line matches an outstanding slot, the slot is freed. fill_valid_o pulses the next cycle with that address.
  - Responses with no matching slot are ignored and produce no pulse.
- Simultaneous events:
  - Enqueue plus pop in one cycle: occupancy is unchanged.
  - Response plus issue handshake in one cycle: both take effect, and a slot freed this cycle may be reused in that same cycle.
  - Dedup uses state as it was before the current cycle's updates.
- Occupancy and pointers are kept with one extra wrap bit so full and empty are distinguishable.

Optional Feature:
- Macro: PREFETCH_QUEUE_STATS_EN.
- When defined:
  - Adds outputs stat_issued_o, stat_dropped_o and stat_squashed_o, each 16 bits.
  - Each is a saturating counter (holds at 65535), reset to 0.
  - Increments are per issue handshake, per dedup drop, and per entry squashed (several entries squashed in one cycle add their count).
- When undefined: these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then enqueue 0x1234 with mem_req_ready_i=1 -> mem_req_address_o=0x1200 two cycles later; mem_resp 0x1200 -> fill_valid_o=1 with fill_address_o=0x1200 the next cycle.
- Hold mem_req_ready_i=0 and enqueue 9 distinct lines (0x100..0x900) -> pf_ready_o=0 after 8 stored (occupancy_o=8); the 9th is not accepted until one entry pops.
- Enqueue 0x500 then 0x5FF -> only one memory request for 0x500; stat_dropped_o=1 with macro defined.
- Queue 0x100, 0x200, 0x300, stall memory, demand 0x2A0 -> 0x200 is never issued; issue order is 0x100, 0x300.
- MAX_OUTSTANDING=4, no responses, 6 queued -> exactly 4 issues. One response frees a slot -> 5th issues; responding to unknown 0xDEAD00 -> no fill pulse.
- Assert rst=0 while in PRESENT -> mem_req_valid_o=0 immediately; after release, occupancy_o=0 and pf_ready_o=1.
